// File: rtl/usb_data_buffer.sv
// Shared TX/RX byte FIFO between the AHB-Lite slave and the USB encoder/decoder.
// Show-ahead head output, registered occupancy, sticky overflow/underflow/collision error flag.
module usb_data_buffer #(
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned ADDR_BITS = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       store_tx_data,
    input  logic [7:0] tx_data,
    input  logic       get_tx_packet_data,
    output logic [7:0] tx_packet_data,
    input  logic       store_rx_packet_data,
    input  logic [7:0] rx_packet_data,
    input  logic       get_rx_data,
    output logic [7:0] rx_data,
    output logic [7:0] buffer_occupancy,
    output logic       buffer_error
);

    localparam logic [ADDR_BITS:0]   FULL_COUNT = DEPTH[ADDR_BITS:0];
    localparam logic [ADDR_BITS:0]   COUNT_ONE  = (ADDR_BITS + 1)'(1);
    localparam logic [ADDR_BITS-1:0] PTR_ONE    = ADDR_BITS'(1);

    logic [7:0]           mem_q [DEPTH];
    logic [ADDR_BITS-1:0] wptr_q, wptr_d;
    logic [ADDR_BITS-1:0] rptr_q, rptr_d;
    logic [ADDR_BITS:0]   count_q, count_d;
    logic                 error_q, error_d;

    logic       push_req, pop_req, collision;
    logic       is_full, is_empty;
    logic       push_ok, pop_ok, mem_we;
    logic [7:0] push_data, head;

    always_comb begin
        push_req  = store_tx_data | store_rx_packet_data;
        pop_req   = get_tx_packet_data | get_rx_data;
        collision = store_tx_data & store_rx_packet_data;
        push_data = store_tx_data ? tx_data : rx_packet_data;
        is_full   = (count_q == FULL_COUNT);
        is_empty  = (count_q == '0);
        // Accept decisions use the pre-edge count, so a pop never frees room for a same-cycle push.
        push_ok   = push_req & ~is_full;
        pop_ok    = pop_req & ~is_empty;
        mem_we    = push_ok & ~clear & ~rst;
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        error_d = error_q;
        if (clear) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            error_d = 1'b0;
        end else begin
            if (push_ok) begin
                wptr_d = wptr_q + PTR_ONE;
            end
            if (pop_ok) begin
                rptr_d = rptr_q + PTR_ONE;
            end
            if (push_ok && !pop_ok) begin
                count_d = count_q + COUNT_ONE;
            end else if (pop_ok && !push_ok) begin
                count_d = count_q - COUNT_ONE;
            end
            if ((push_req && is_full) || (pop_req && is_empty) || collision) begin
                error_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            error_q <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            error_q <= error_d;
        end
    end

    // Storage is deliberately not reset; clear/reset only move the pointers.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wptr_q] <= push_data;
        end
    end

    always_comb begin
        head = is_empty ? 8'h00 : mem_q[rptr_q];
    end

    assign tx_packet_data   = head;
    assign rx_data          = head;
    assign buffer_occupancy = 8'(count_q);
    assign buffer_error     = error_q;

endmodule

// File: tb/tb_usb_data_buffer.sv
// Directed self-checking bench for usb_data_buffer.
// Inputs change #1 after a rising edge; outputs are checked at that same point.
module tb_usb_data_buffer;

    logic       clk = 1'b0;
    logic       rst, clear;
    logic       store_tx_data, store_rx_packet_data;
    logic [7:0] tx_data, rx_packet_data;
    logic       get_tx_packet_data, get_rx_data;
    logic [7:0] tx_packet_data, rx_data, buffer_occupancy;
    logic       buffer_error;

    int checks   = 0;
    int failures = 0;

    usb_data_buffer #(
        .DEPTH    (64),
        .ADDR_BITS(6)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .clear               (clear),
        .store_tx_data       (store_tx_data),
        .tx_data             (tx_data),
        .get_tx_packet_data  (get_tx_packet_data),
        .tx_packet_data      (tx_packet_data),
        .store_rx_packet_data(store_rx_packet_data),
        .rx_packet_data      (rx_packet_data),
        .get_rx_data         (get_rx_data),
        .rx_data             (rx_data),
        .buffer_occupancy    (buffer_occupancy),
        .buffer_error        (buffer_error)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock with the given request pattern, then return all requests low.
    task automatic cycle(input logic stx, input logic [7:0] txd, input logic srx,
                         input logic [7:0] rxd, input logic gtx, input logic grx,
                         input logic clr, input logic r);
        store_tx_data        = stx;
        tx_data              = txd;
        store_rx_packet_data = srx;
        rx_packet_data       = rxd;
        get_tx_packet_data   = gtx;
        get_rx_data          = grx;
        clear                = clr;
        rst                  = r;
        @(posedge clk);
        #1;
        store_tx_data        = 1'b0;
        store_rx_packet_data = 1'b0;
        get_tx_packet_data   = 1'b0;
        get_rx_data          = 1'b0;
        clear                = 1'b0;
        rst                  = 1'b0;
    endtask

    task automatic push_tx(input logic [7:0] d);
        cycle(1'b1, d, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic push_rx(input logic [7:0] d);
        cycle(1'b0, 8'h00, 1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop_tx();
        cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop_rx();
        cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_clear();
        cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        store_tx_data = 0; store_rx_packet_data = 0; tx_data = 0; rx_packet_data = 0;
        get_tx_packet_data = 0; get_rx_data = 0; clear = 0; rst = 1;

        // Reset then idle
        cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("rst_occ", buffer_occupancy, 0);
        check_eq("rst_tx", tx_packet_data, 8'h00);
        check_eq("rst_rx", rx_data, 8'h00);
        check_eq("rst_err", buffer_error, 0);

        // Single push/pop
        push_tx(8'hAA);
        check_eq("push1_occ", buffer_occupancy, 1);
        check_eq("push1_tx", tx_packet_data, 8'hAA);
        check_eq("push1_rx", rx_data, 8'hAA);
        pop_tx();
        check_eq("pop1_occ", buffer_occupancy, 0);
        check_eq("pop1_tx", tx_packet_data, 8'h00);
        check_eq("pop1_err", buffer_error, 0);

        // Fill to full, overflow, drain in order
        for (int i = 0; i < 64; i++) push_tx(8'(i));
        check_eq("full_occ", buffer_occupancy, 64);
        check_eq("full_err", buffer_error, 0);
        push_tx(8'hFF);
        check_eq("ovf_occ", buffer_occupancy, 64);
        check_eq("ovf_err", buffer_error, 1);
        for (int i = 0; i < 64; i++) begin
            check_eq($sformatf("drain_%0d", i), tx_packet_data, 32'(i));
            if (i % 2 == 0) pop_tx(); else pop_rx();
        end
        check_eq("drain_occ", buffer_occupancy, 0);
        check_eq("drain_head", rx_data, 8'h00);
        check_eq("err_sticky", buffer_error, 1);
        pop_tx();
        check_eq("udf_occ", buffer_occupancy, 0);

        // Wrap-around
        do_clear();
        check_eq("clr_err", buffer_error, 0);
        for (int i = 0; i < 40; i++) push_rx(8'(i + 8'h40));
        for (int i = 0; i < 40; i++) pop_rx();
        for (int i = 0; i < 30; i++) push_tx(8'(8'h80 + i));
        check_eq("wrap_occ", buffer_occupancy, 30);
        for (int i = 0; i < 30; i++) begin
            check_eq($sformatf("wrap_%0d", i), rx_data, 32'(8'h80 + i));
            pop_rx();
        end
        check_eq("wrap_end_occ", buffer_occupancy, 0);
        check_eq("wrap_err", buffer_error, 0);

        // Push + pop with occupancy 5
        for (int i = 0; i < 5; i++) push_tx(8'(8'h10 + i));
        cycle(1'b1, 8'h55, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("pp5_occ", buffer_occupancy, 5);
        check_eq("pp5_head", tx_packet_data, 8'h11);
        check_eq("pp5_err", buffer_error, 0);
        for (int i = 0; i < 5; i++) pop_tx();
        check_eq("pp5_drain_occ", buffer_occupancy, 0);

        // Push + pop while empty
        cycle(1'b1, 8'h66, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("ppe_occ", buffer_occupancy, 1);
        check_eq("ppe_err", buffer_error, 1);
        check_eq("ppe_head", tx_packet_data, 8'h66);

        // TX/RX collision
        do_clear();
        cycle(1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("col_head", tx_packet_data, 8'h11);
        check_eq("col_occ", buffer_occupancy, 1);
        check_eq("col_err", buffer_error, 1);

        // Clear mid-stream together with a push
        for (int i = 0; i < 9; i++) push_tx(8'(8'hC0 + i));
        check_eq("pre_clr_occ", buffer_occupancy, 10);
        cycle(1'b1, 8'hEE, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("clr_occ", buffer_occupancy, 0);
        check_eq("clr_err2", buffer_error, 0);
        check_eq("clr_head", tx_packet_data, 8'h00);
        push_tx(8'h5A);
        check_eq("post_clr_head", tx_packet_data, 8'h5A);

        // Same with rst (error set first via collision)
        cycle(1'b1, 8'h01, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) push_rx(8'(i));
        check_eq("pre_rst_occ", buffer_occupancy, 10);
        check_eq("pre_rst_err", buffer_error, 1);
        cycle(1'b1, 8'hEE, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        check_eq("rst2_occ", buffer_occupancy, 0);
        check_eq("rst2_err", buffer_error, 0);
        check_eq("rst2_head", rx_data, 8'h00);
        push_rx(8'h3C);
        check_eq("post_rst_head", rx_data, 8'h3C);
        check_eq("post_rst_occ", buffer_occupancy, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
